// File: rtl/family_selector_if.sv
// Bus bundle between the mutation iterator / distance ROM side and family_selector.
// The selector sits on the slave modport; the producer/ROM side uses master.
interface family_selector_if #(
  parameter int GENE_W    = 5,
  parameter int NUM_GENES = 30,
  parameter int FAMILY_N  = 5,
  parameter int DIST_W    = 8,
  parameter int COST_W    = 16
);
  localparam int MEMBER_W = GENE_W * NUM_GENES;

  logic                         start;
  logic [MEMBER_W*FAMILY_N-1:0] family;
  logic [GENE_W-1:0]            dist_a;
  logic [GENE_W-1:0]            dist_b;
  logic [DIST_W-1:0]            dist_data;
  logic [MEMBER_W-1:0]          best;
  logic [COST_W-1:0]            best_cost;
  logic [2:0]                   best_index;
  logic                         done;

  modport master (
    output start, family, dist_data,
    input  dist_a, dist_b, best, best_cost, best_index, done
  );

  modport slave (
    input  start, family, dist_data,
    output dist_a, dist_b, best, best_cost, best_index, done
  );
endinterface

// File: rtl/family_selector.sv
// Scores each family member as a closed tour using an external registered distance ROM
// and presents the cheapest member (earliest index on ties) with a one-cycle done pulse.
module family_selector #(
  parameter int GENE_W    = 5,
  parameter int NUM_GENES = 30,
  parameter int FAMILY_N  = 5,
  parameter int DIST_W    = 8,
  parameter int COST_W    = 16
) (
  input logic clk,
  input logic rst,
  family_selector_if.slave bus
);
  localparam int MEMBER_W = GENE_W * NUM_GENES;
  localparam int FAMILY_W = MEMBER_W * FAMILY_N;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMPARE, DONE} state_t;

  state_t              state;
  logic [FAMILY_W-1:0] fam_reg;
  logic [2:0]          m;
  logic [4:0]          k;
  logic [COST_W-1:0]   acc;
  logic [MEMBER_W-1:0] run_best;
  logic [COST_W-1:0]   run_best_cost;
  logic [2:0]          run_best_idx;

  logic [GENE_W-1:0]   dist_a_q;
  logic [GENE_W-1:0]   dist_b_q;
  logic [MEMBER_W-1:0] best_q;
  logic [COST_W-1:0]   best_cost_q;
  logic [2:0]          best_index_q;
  logic                done_q;

  logic [MEMBER_W-1:0] cur_member;
  logic [MEMBER_W-1:0] nxt_member;
  logic [2:0]          next_m;
  logic [COST_W-1:0]   dist_ext;
  logic [GENE_W-1:0]   look_a;
  logic [GENE_W-1:0]   look_b;
  logic                take_new;
  logic [MEMBER_W-1:0] cand_best;
  logic [COST_W-1:0]   cand_cost;
  logic [2:0]          cand_idx;

  // Addresses are registered one step ahead so each pair is on the bus in its own FETCH cycle.
  always_comb begin
    next_m     = (m == 3'(FAMILY_N - 1)) ? 3'd0 : m + 3'd1;
    cur_member = fam_reg[int'(m) * MEMBER_W +: MEMBER_W];
    nxt_member = fam_reg[int'(next_m) * MEMBER_W +: MEMBER_W];
    dist_ext   = {{(COST_W - DIST_W){1'b0}}, bus.dist_data};
    look_a     = cur_member[((int'(k) + 1) % NUM_GENES) * GENE_W +: GENE_W];
    look_b     = cur_member[((int'(k) + 2) % NUM_GENES) * GENE_W +: GENE_W];
    take_new   = acc < run_best_cost;
    cand_best  = take_new ? cur_member : run_best;
    cand_cost  = take_new ? acc : run_best_cost;
    cand_idx   = take_new ? m : run_best_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fam_reg       <= '0;
      m             <= '0;
      k             <= '0;
      acc           <= '0;
      run_best      <= '0;
      run_best_cost <= '0;
      run_best_idx  <= '0;
      dist_a_q      <= '0;
      dist_b_q      <= '0;
      best_q        <= '0;
      best_cost_q   <= '0;
      best_index_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            fam_reg       <= bus.family;
            dist_a_q      <= bus.family[0 +: GENE_W];
            dist_b_q      <= bus.family[GENE_W +: GENE_W];
            m             <= '0;
            k             <= '0;
            acc           <= '0;
            run_best_cost <= '1;
            state         <= FETCH;
          end
        end
        FETCH: begin
          // dist_data during k=0 belongs to an earlier address, so it is skipped.
          if (k != 5'd0) acc <= acc + dist_ext;
          if (k == 5'(NUM_GENES - 1)) begin
            state <= DRAIN;
          end else begin
            k        <= k + 5'd1;
            dist_a_q <= look_a;
            dist_b_q <= look_b;
          end
        end
        DRAIN: begin
          acc   <= acc + dist_ext;
          state <= COMPARE;
        end
        COMPARE: begin
          run_best      <= cand_best;
          run_best_cost <= cand_cost;
          run_best_idx  <= cand_idx;
          acc           <= '0;
          if (m < 3'(FAMILY_N - 1)) begin
            m        <= next_m;
            k        <= '0;
            dist_a_q <= nxt_member[0 +: GENE_W];
            dist_b_q <= nxt_member[GENE_W +: GENE_W];
            state    <= FETCH;
          end else begin
            best_q       <= cand_best;
            best_cost_q  <= cand_cost;
            best_index_q <= cand_idx;
            done_q       <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dist_a     = dist_a_q;
  assign bus.dist_b     = dist_b_q;
  assign bus.best       = best_q;
  assign bus.best_cost  = best_cost_q;
  assign bus.best_index = best_index_q;
  assign bus.done       = done_q;
endmodule
